// File: rtl/tick_sched.sv
// tick_sched: round-robin sharing of one prescaled tick timer among N_REQ requesters.
// Define TICK_SCHED_ABORT_EN to let a granted requester abort its delay by dropping req.
module tick_sched #(
    parameter int N_REQ    = 4,
    parameter int PRESCALE = 255,
    parameter int DW       = 8
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] delay,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    done,
    output logic                tick,
    output logic                busy
);

    localparam int PW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
    localparam int IW = $clog2(N_REQ);
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE);
    localparam logic [IW-1:0] IDX_MAX = IW'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] idx);
        logic [N_REQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        logic [IW-1:0] nxt;
        if (idx == IDX_MAX) begin
            nxt = '0;
        end else begin
            nxt = idx + IW'(1);
        end
        return nxt;
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic [PW-1:0]     pre_r;
    logic [PW-1:0]     pre_nxt_s;
    logic [DW-1:0]     rem_r;
    logic [DW-1:0]     rem_nxt_s;
    logic [IW-1:0]     ptr_r;
    logic [IW-1:0]     ptr_nxt_s;
    logic [IW-1:0]     idx_r;
    logic [IW-1:0]     idx_nxt_s;
    logic [N_REQ-1:0]  gnt_r;
    logic [N_REQ-1:0]  gnt_nxt_s;
    logic [N_REQ-1:0]  done_r;
    logic [N_REQ-1:0]  done_nxt_s;
    logic              tick_r;
    logic              tick_nxt_s;
    logic              busy_r;
    logic              busy_nxt_s;

    logic              win_found_s;
    logic [IW-1:0]     win_idx_s;
    logic [IW-1:0]     cand_idx_s;
    int                cand_s;
    logic [DW-1:0]     sel_delay_s;
    logic              wrap_s;
    logic              last_tick_s;
    logic              abort_s;

    assign gnt  = gnt_r;
    assign done = done_r;
    assign tick = tick_r;
    assign busy = busy_r;

    // Round-robin scan: first pending request at or after the pointer, wrapping.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand_idx_s  = '0;
        cand_s      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_s = int'(ptr_r) + k;
            if (cand_s >= N_REQ) begin
                cand_s = cand_s - N_REQ;
            end else begin
                cand_s = cand_s;
            end
            cand_idx_s = IW'(cand_s);
            if (!win_found_s && req[cand_idx_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_idx_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    assign sel_delay_s = delay[int'(win_idx_s)*DW +: DW];
    assign wrap_s      = (pre_r == PRE_MAX);
    assign last_tick_s = wrap_s && (rem_r == DW'(1));

`ifdef TICK_SCHED_ABORT_EN
    assign abort_s = (state_r == ST_RUN) && !req[idx_r];
`else
    assign abort_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; DONE holds until its done pulse has been driven.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    if (sel_delay_s == DW'(0)) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (last_tick_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (|done_r) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Next values of the datapath and of every registered output.
    always_comb begin
        pre_nxt_s  = pre_r;
        rem_nxt_s  = rem_r;
        ptr_nxt_s  = ptr_r;
        idx_nxt_s  = idx_r;
        gnt_nxt_s  = gnt_r;
        done_nxt_s = '0;
        tick_nxt_s = 1'b0;
        busy_nxt_s = (state_nxt_s != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    idx_nxt_s = win_idx_s;
                    gnt_nxt_s = onehot(win_idx_s);
                    rem_nxt_s = sel_delay_s;
                    pre_nxt_s = '0;
                end else begin
                    gnt_nxt_s = '0;
                end
            end
            ST_RUN: begin
                if (abort_s) begin
                    gnt_nxt_s = '0;
                    ptr_nxt_s = next_idx(idx_r);
                end else if (wrap_s) begin
                    pre_nxt_s  = '0;
                    tick_nxt_s = 1'b1;
                    rem_nxt_s  = rem_r - DW'(1);
                    if (last_tick_s) begin
                        done_nxt_s = onehot(idx_r);
                    end else begin
                        done_nxt_s = '0;
                    end
                end else begin
                    pre_nxt_s = pre_r + PW'(1);
                end
            end
            ST_DONE: begin
                if (|done_r) begin
                    gnt_nxt_s = '0;
                    ptr_nxt_s = next_idx(idx_r);
                end else begin
                    done_nxt_s = onehot(idx_r);
                end
            end
            default: begin
                gnt_nxt_s = '0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            pre_r  <= '0;
            rem_r  <= '0;
            ptr_r  <= '0;
            idx_r  <= '0;
            gnt_r  <= '0;
            done_r <= '0;
            tick_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            pre_r  <= pre_nxt_s;
            rem_r  <= rem_nxt_s;
            ptr_r  <= ptr_nxt_s;
            idx_r  <= idx_nxt_s;
            gnt_r  <= gnt_nxt_s;
            done_r <= done_nxt_s;
            tick_r <= tick_nxt_s;
            busy_r <= busy_nxt_s;
        end
    end

endmodule

// File: tb/tb_tick_sched.sv
// tb_tick_sched: directed scenarios with literal expectations plus a randomized run,
// all checked every cycle against a timeline model of grants, ticks and completions.
module tb_tick_sched;

    localparam int N     = 4;
    localparam int PRESC = 3;
    localparam int DW    = 8;
    localparam int PER   = PRESC + 1;
`ifdef TICK_SCHED_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          n_reset;
    logic [N-1:0]  req;
    logic [N*DW-1:0] delay;
    logic [N-1:0]  gnt;
    logic [N-1:0]  done;
    logic          tick;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;
    int ncyc = 0;
    bit chk_en = 1'b0;

    // Model state: who owns the timer and when its grant happened.
    int owner = -1;
    int g_cyc = 0;
    int d_lat = 0;
    int done_cyc = 0;
    int ptr_m = 0;
    int mcyc = 0;
    logic [N-1:0] exp_gnt = '0;
    logic [N-1:0] exp_done = '0;
    logic         exp_tick = 1'b0;
    logic         exp_busy = 1'b0;

    tick_sched #(.N_REQ(N), .PRESCALE(PRESC), .DW(DW)) dut (
        .clk(clk), .n_reset(n_reset), .req(req), .delay(delay),
        .gnt(gnt), .done(done), .tick(tick), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        ncyc++;
    endtask

    task automatic do_reset();
        n_reset = 1'b0;
        req     = '0;
        delay   = '0;
        repeat (2) step();
        n_reset = 1'b1;
        step();
    endtask

    task automatic wait_gnt(input logic [N-1:0] mask, input int budget, output int at);
        at = -1;
        for (int k = 0; k < budget; k++) begin
            if ((gnt & mask) != '0) begin
                at = ncyc;
                break;
            end
            step();
        end
        if (at < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL gnt_timeout: no grant for mask %b within %0d cycles", mask, budget);
        end
    endtask

    task automatic wait_done(input logic [N-1:0] mask, input int budget, output int at, output int ticks);
        at    = -1;
        ticks = 0;
        for (int k = 0; k < budget; k++) begin
            step();
            if (tick) ticks++;
            if ((done & mask) != '0) begin
                at = ncyc;
                break;
            end
        end
        if (at < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: no done for mask %b within %0d cycles", mask, budget);
        end
    endtask

    // Reference model: grant timeline computed from the scheduling rules.
    initial forever begin
        @(posedge clk or negedge n_reset);
        if (!n_reset) begin
            owner = -1;
            ptr_m = 0;
            mcyc  = 0;
        end else begin
            mcyc++;
            if (owner >= 0) begin
                if (ABORT && d_lat > 0 && mcyc <= done_cyc && !req[owner]) begin
                    ptr_m = (owner + 1) % N;
                    owner = -1;
                end else if (mcyc == done_cyc + 1) begin
                    ptr_m = (owner + 1) % N;
                    owner = -1;
                end
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (owner < 0 && req[(ptr_m + k) % N]) begin
                        owner    = (ptr_m + k) % N;
                        g_cyc    = mcyc;
                        d_lat    = int'(delay[owner*DW +: DW]);
                        done_cyc = mcyc + ((d_lat == 0) ? 1 : d_lat * PER);
                    end
                end
            end
        end
        exp_gnt  = (owner >= 0) ? N'(1 << owner) : '0;
        exp_done = (owner >= 0 && mcyc == done_cyc) ? N'(1 << owner) : '0;
        exp_busy = (owner >= 0);
        exp_tick = (owner >= 0) && (d_lat > 0) && (mcyc > g_cyc) && (mcyc <= done_cyc)
                   && ((mcyc - g_cyc) % PER == 0);
    end

    // Per-cycle comparison of the DUT against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("cyc_gnt",  int'(gnt),  int'(exp_gnt));
            check("cyc_done", int'(done), int'(exp_done));
            check("cyc_tick", int'(tick), int'(exp_tick));
            check("cyc_busy", int'(busy), int'(exp_busy));
        end
    end

    initial begin
        int tg, td, tk, prev, who, ndone;
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        n_reset = 1'b1;
        req     = '0;
        delay   = '0;
        #2;
        chk_en  = 1'b1;
        do_reset();
        check("rst_gnt",  int'(gnt),  0);
        check("rst_done", int'(done), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_busy", int'(busy), 0);

        // Reset in the middle of RUN, then pointer must be back at 0.
        req   = 4'b0010;
        delay = {8'd0, 8'd0, 8'd5, 8'd0};
        wait_gnt(4'b0010, 10, tg);
        repeat (6) step();
        check("t1_busy_run", int'(busy), 1);
        #2 n_reset = 1'b0;
        #1;
        check("t1_async_gnt",  int'(gnt),  0);
        check("t1_async_done", int'(done), 0);
        check("t1_async_tick", int'(tick), 0);
        check("t1_async_busy", int'(busy), 0);
        req   = 4'b0011;
        delay = {8'd1, 8'd1, 8'd1, 8'd1};
        step();
        n_reset = 1'b1;
        wait_gnt(4'b0011, 10, tg);
        check("t1_regrant_req0", int'(gnt), 1);
        do_reset();

        // Single request, delay 5.
        req   = 4'b0001;
        delay = {8'd0, 8'd0, 8'd0, 8'd5};
        prev  = ncyc;
        wait_gnt(4'b0001, 10, tg);
        check("t2_gnt", int'(gnt), 1);
        check("t2_gnt_latency", tg - prev, 1);
        wait_done(4'b0001, 40, td, tk);
        check("t2_done_latency", td - tg, 20);
        check("t2_tick_count", tk, 5);
        req = '0;
        step();
        check("t2_gnt_clear", int'(gnt), 0);

        // Contention from reset: 0,1,2,3,0 with one idle clock between grants.
        do_reset();
        req   = 4'b1111;
        delay = {8'd1, 8'd1, 8'd1, 8'd1};
        prev  = -1;
        for (int j = 0; j < 5; j++) begin
            wait_gnt(4'b1111, 20, tg);
            who = -1;
            for (int b = 0; b < N; b++) if (gnt[b]) who = b;
            check("t3_order", who, exp_order[j]);
            if (prev >= 0) check("t3_grant_spacing", tg - prev, 6);
            prev = tg;
            wait_done(4'b1111, 20, td, tk);
            check("t3_done_latency", td - tg, 4);
            step();
            check("t3_idle_gap", int'(gnt), 0);
        end
        req = '0;
        repeat (8) step();

        // Zero delay.
        req   = 4'b0100;
        delay = '0;
        wait_gnt(4'b0100, 10, tg);
        check("t4_gnt", int'(gnt), 4);
        check("t4_no_tick_at_gnt", int'(tick), 0);
        step();
        check("t4_done_next", int'(done), 4);
        check("t4_no_tick_at_done", int'(tick), 0);
        req = '0;
        step();
        check("t4_gnt_clear", int'(gnt), 0);

        // Request dropped 6 clocks into a delay of 10.
        req   = 4'b0010;
        delay = {8'd0, 8'd0, 8'd10, 8'd0};
        wait_gnt(4'b0010, 10, tg);
        repeat (5) step();
        req = '0;
`ifdef TICK_SCHED_ABORT_EN
        step();
        check("t5_abort_gnt", int'(gnt), 0);
        ndone = 0;
        for (int k = 0; k < 45; k++) begin
            step();
            if (done != '0) ndone++;
        end
        check("t5_abort_no_done", ndone, 0);
`else
        wait_done(4'b0010, 60, td, tk);
        check("t5_done_latency", td - tg, 40);
        ndone = 1;
`endif
        req   = 4'b0101;
        delay = {8'd1, 8'd1, 8'd1, 8'd1};
        wait_gnt(4'b0101, 10, tg);
        check("t5_scan_from_2", int'(gnt), 4);
        wait_done(4'b0100, 20, td, tk);
        req = '0;
        repeat (4) step();

        // Randomized traffic; delays are rerolled every cycle to show grant-time sampling.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 9) == 0)
                    delay[i*DW +: DW] = 8'($urandom_range(0, 12));
                else
                    delay[i*DW +: DW] = 8'($urandom_range(0, 3));
                if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
                end else if (exp_done[i]) begin
                    if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                end else if (ABORT && exp_gnt[i] && $urandom_range(0, 40) == 0) begin
                    req[i] = 1'b0;
                end
            end
            step();
        end
        req = '0;
        for (int k = 0; k < 300 && busy; k++) step();
        step();
        check("drain_idle", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
